goertzel_bin_scheduler: RTL
===========================

Name: goertzel_bin_scheduler

Overview:
Sequences one shared Goertzel core across NBINS frequency bins per frame of NS samples.
- Buffers an incoming sample frame and holds a per-bin coefficient table (alpha, cW_re, cW_im).
- For each bin in turn: clears the core, feeds it the frame one sample per cycle, captures its magnitude, and emits it on a result stream tagged with the bin index.
- Sits between the ADC sample stream and the tone-detection logic.

Parameters:
NS, 10, samples per frame; must match the core's NS.
NBINS, 4, number of bins processed per frame; 1..16.
TIMEOUT, 64, cycles allowed after core_en rises for core_ready to assert.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
cfg_we  in  1  coefficient write strobe
cfg_addr  in  4  bin index of write
cfg_sel  in  2  0=alpha, 1=cW_re, 2=cW_im, 3=ignored
cfg_wdata  in  32  signed coefficient value
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid&s_ready
s_data  in  32  signed sample
core_rstn  out  1  core reset (active low)
core_en  out  1  core enable
core_ready  in  1  core result valid
core_alpha  out  32  alpha to core
core_cw_re  out  32  cW_re to core
core_cw_im  out  32  cW_im to core
core_data  out  32  sample to core
core_data_o  in  32  core magnitude
m_valid  out  1  result valid
m_ready  in  1  result accepted
m_bin  out  4  bin index of result
m_mag  out  32  unsigned magnitude
m_last  out  1  last bin of frame
busy  out  1  high in any state except FILL
err  out  1  sticky timeout flag (TIMEOUT_EN only)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rstn. Reset applies at any time, including mid-frame.
- Reset values:
  - Outputs: s_ready=1, core_rstn=0, core_en=0, m_valid=0, m_bin=0, m_mag=0, m_last=0, busy=0, err=0.
  - State FILL; sample counter, bin counter and run counter all 0.
  - Coefficient table cleared to 0.
  - Sample buffer contents are don't-care.
- States: FILL -> CLR -> RUN -> OUT -> (CLR for next bin | FILL after last bin).
- FILL:
  - s_ready=1; each accepted sample is written to buf[scnt] and scnt increments.
  - When the NS-th sample is accepted: scnt=0, bin=0, next state CLR.
  - s_ready is 0 in all other states, so no samples are dropped.
- CLR (1 cycle):
  - core_rstn=0.
  - Table entry [bin] is latched into core_alpha/core_cw_re/core_cw_im. These are held stable through RUN, so table writes during RUN do not corrupt the bin in progress.
- RUN:
  - core_rstn=1, core_en=1.
  - core_data=buf[k]. k starts at 0 on the first RUN cycle, increments each cycle, and saturates at NS-1.
  - On core_ready=1: m_mag<=core_data_o, m_bin<=bin, m_last<=(bin==NBINS-1), m_valid<=1, core_en<=0, next state OUT.
- OUT:
  - Hold m_* until m_valid&m_ready.
  - Then m_valid<=0. If bin<NBINS-1: bin++, next CLR. Otherwise next FILL and s_ready<=1.
- core_rstn = registered value AND rstn, so the core resets whenever the controller does.
- Per-bin latency with m_ready held high: 1 (CLR) + cycles until core_ready + 1 (OUT). Results appear in bin order 0..NBINS-1.
- Coefficient writes:
  - Accepted in any state; take effect from the next CLR.
  - cfg_addr>=NBINS or cfg_sel==3: write ignored.
- Boundaries:
  - m_ready may be held low indefinitely; the scheduler stalls in OUT.
  - s_valid while busy: not accepted.
  - NBINS=1: each OUT returns to FILL with m_last=1.

Optional Feature:
GOERTZEL_TIMEOUT_EN.
- Defined:
  - A run counter counts RUN cycles. If it reaches TIMEOUT without core_ready: err<=1 (sticky until reset), core_en<=0.
  - m_mag=32'hFFFF_FFFF and m_valid=1 for that bin, then sequencing continues normally.
- Undefined: no counter, err tied 0, RUN waits indefinitely.

Decomposition:
- Package goertzel_pkg:
  - state enum sched_state_e {FILL, CLR, RUN, OUT}.
  - coef_sel_e {SEL_ALPHA, SEL_CW_RE, SEL_CW_IM}.
  - struct goertzel_coef_t {alpha, cw_re, cw_im : signed 32}.
  - Constant BIN_W=4.
- Sub-module goertzel_coef_table: NBINS-entry register array, with a write port (we/addr/sel/wdata) and a combinational read port addressed by bin.

Test Plan:
- Bench uses a core stub that asserts core_ready NS+1 cycles after core_en rises and returns core_data_o = core_alpha + sum of the core_data it received.
- Defaults; alpha[b]=b*100; samples 1..10 -> four results: m_bin 0..3, m_mag 55,155,255,355, m_last only on bin 3; s_ready returns to 1 after.
- Hold m_ready=0 for 20 cycles on bin 1 -> m_bin=1/m_mag=155 held stable, core_en=0, bin 2 starts only after the handshake.
- Write alpha[0]=7 during RUN of bin 0 -> bin 0 result 55; next frame bin 0 result 62.
- Assert rstn=0 for 1 cycle during RUN of bin 2 -> all outputs at reset values; core_rstn=0; next frame starts from scnt=0, bin 0.
- With GOERTZEL_TIMEOUT_EN, stub never asserts ready on bin 1 -> after 64 RUN cycles err=1, m_mag=FFFF_FFFF for bin 1, bins 2-3 report normally.

Source files
------------

// File: rtl/goertzel_pkg.sv
// Shared types for the Goertzel bin scheduler.
package goertzel_pkg;
  localparam int BIN_W = 4;

  typedef enum logic [1:0] {
    FILL, CLR, RUN, OUT
  } sched_state_e;

  typedef enum logic [1:0] {
    SEL_ALPHA, SEL_CW_RE, SEL_CW_IM
  } coef_sel_e;

  typedef struct packed {
    logic signed [31:0] alpha;
    logic signed [31:0] cw_re;
    logic signed [31:0] cw_im;
  } goertzel_coef_t;
endpackage

// File: rtl/goertzel_bin_scheduler_if.sv
// Sample-in and result-out streams of the bin scheduler.
interface goertzel_bin_scheduler_if;
  import goertzel_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             m_valid;
  logic             m_ready;
  logic [BIN_W-1:0] m_bin;
  logic [31:0]      m_mag;
  logic             m_last;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_bin, m_mag, m_last
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_bin, m_mag, m_last
  );
endinterface

// File: rtl/goertzel_coef_table.sv
// Per-bin coefficient registers: one write port, one combinational read.
module goertzel_coef_table
  import goertzel_pkg::*;
#(
  parameter int NBINS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [BIN_W-1:0] addr,
  input  logic [1:0]       sel,
  input  logic [31:0]      wdata,
  input  logic [BIN_W-1:0] rd_bin,
  output goertzel_coef_t   rd
);

  goertzel_coef_t tbl [NBINS];

  // out-of-range addresses match no entry and are dropped
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NBINS; i++) tbl[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NBINS; i++) begin
        if (addr == BIN_W'(i)) begin
          case (sel)
            SEL_ALPHA: tbl[i].alpha <= wdata;
            SEL_CW_RE: tbl[i].cw_re <= wdata;
            SEL_CW_IM: tbl[i].cw_im <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NBINS; i++) begin
      if (rd_bin == BIN_W'(i)) rd = tbl[i];
    end
  end

endmodule

// File: rtl/goertzel_bin_scheduler.sv
// Time-shares one Goertzel core over NBINS bins per buffered frame.
// Optional run timeout: define GOERTZEL_TIMEOUT_EN.
module goertzel_bin_scheduler
  import goertzel_pkg::*;
#(
  parameter int NS      = 10,
  parameter int NBINS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_we,
  input  logic [BIN_W-1:0] cfg_addr,
  input  logic [1:0]       cfg_sel,
  input  logic [31:0]      cfg_wdata,
  goertzel_bin_scheduler_if.master io,
  output logic             core_rstn,
  output logic             core_en,
  input  logic             core_ready,
  output logic [31:0]      core_alpha,
  output logic [31:0]      core_cw_re,
  output logic [31:0]      core_cw_im,
  output logic [31:0]      core_data,
  input  logic [31:0]      core_data_o,
  output logic             busy,
  output logic             err
);

  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(NS - 1);
  localparam logic [BIN_W-1:0] B_LAST = BIN_W'(NBINS - 1);

  sched_state_e     st;
  logic [SW-1:0]    scnt;
  logic [SW-1:0]    k;
  logic [BIN_W-1:0] bin;
  logic [31:0]      sbuf [NS];
  logic             core_rq;
  logic             s_rdy;
  logic             m_vld;
  logic [BIN_W-1:0] m_b;
  logic [31:0]      m_m;
  logic             m_lst;
  goertzel_coef_t   coef;
  goertzel_coef_t   cur;
  logic             take;
  logic             to_hit;

  assign take = io.s_valid & s_rdy;

  goertzel_coef_table #(.NBINS(NBINS)) u_tbl (
    .clk    (clk),
    .rstn   (rstn),
    .we     (cfg_we),
    .addr   (cfg_addr),
    .sel    (cfg_sel),
    .wdata  (cfg_wdata),
    .rd_bin (bin),
    .rd     (coef)
  );

`ifdef GOERTZEL_TIMEOUT_EN
  localparam int RW = $clog2(TIMEOUT + 1);
  logic [RW-1:0] rcnt;
  logic          err_q;
  assign to_hit = (rcnt == RW'(TIMEOUT - 1));
  assign err    = err_q;
`else
  wire unused_to = (TIMEOUT > 0);
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // frame buffer holds no reset; contents only matter once refilled
  always_ff @(posedge clk) begin
    if (take) sbuf[scnt] <= io.s_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st      <= FILL;
      scnt    <= '0;
      k       <= '0;
      bin     <= '0;
      s_rdy   <= 1'b1;
      busy    <= 1'b0;
      core_rq <= 1'b0;
      core_en <= 1'b0;
      cur     <= '0;
      m_vld   <= 1'b0;
      m_b     <= '0;
      m_m     <= '0;
      m_lst   <= 1'b0;
`ifdef GOERTZEL_TIMEOUT_EN
      rcnt    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (st)
        FILL: begin
          if (take) begin
            if (scnt == S_LAST) begin
              scnt    <= '0;
              bin     <= '0;
              s_rdy   <= 1'b0;
              busy    <= 1'b1;
              core_rq <= 1'b0;
              st      <= CLR;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        CLR: begin
          cur     <= coef;
          core_rq <= 1'b1;
          core_en <= 1'b1;
          k       <= '0;
`ifdef GOERTZEL_TIMEOUT_EN
          rcnt    <= '0;
`endif
          st      <= RUN;
        end
        RUN: begin
          if (k != S_LAST) k <= k + 1'b1;
          if (core_ready || to_hit) begin
            m_m     <= core_ready ? core_data_o : '1;
            m_b     <= bin;
            m_lst   <= (bin == B_LAST);
            m_vld   <= 1'b1;
            core_en <= 1'b0;
            st      <= OUT;
          end
`ifdef GOERTZEL_TIMEOUT_EN
          if (!core_ready) begin
            rcnt <= rcnt + 1'b1;
            if (to_hit) err_q <= 1'b1;
          end
`endif
        end
        OUT: begin
          if (m_vld && io.m_ready) begin
            m_vld <= 1'b0;
            if (bin != B_LAST) begin
              bin     <= bin + 1'b1;
              core_rq <= 1'b0;
              st      <= CLR;
            end else begin
              s_rdy <= 1'b1;
              busy  <= 1'b0;
              st    <= FILL;
            end
          end
        end
        default: st <= FILL;
      endcase
    end
  end

  assign core_rstn  = core_rq & rstn;
  assign core_alpha = cur.alpha;
  assign core_cw_re = cur.cw_re;
  assign core_cw_im = cur.cw_im;
  assign core_data  = sbuf[k];

  assign io.s_ready = s_rdy;
  assign io.m_valid = m_vld;
  assign io.m_bin   = m_b;
  assign io.m_mag   = m_m;
  assign io.m_last  = m_lst;

endmodule
